// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipe: tracks EX/MEM/WB register tags,
// drives operand-forward and regfile-bypass selects, and stalls/flushes/freezes the front end.
module hazard_fwd_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             rf_byp_rs,
  output logic             rf_byp_rt,
  output logic             pc_hold,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MEMWAIT} state_t;

  state_t state, state_nxt;

  logic [RA_W-1:0]  ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic             ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic             init;
  logic             active;
  logic             id_nop;
  logic             load_use;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic [RA_W-1:0] m_rd, input logic m_rw,
                                         input logic [RA_W-1:0] w_rd, input logic w_rw);
    if (m_rw && m_rd != '0 && m_rd == src)      return 2'b01;
    else if (w_rw && w_rd != '0 && w_rd == src) return 2'b10;
    else                                        return 2'b00;
  endfunction

  // Outputs are quiet during reset and for one settling cycle afterwards.
  assign active   = !reset && !init;
  assign id_nop   = (state == FLUSH);
  assign load_use = !id_nop && ex_memread && ex_rd != '0 &&
                    ((ex_rd == id_rs && id_use_rs) || (ex_rd == id_rt && id_use_rt));

  assign fwd_a_sel = active ? fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
  assign fwd_b_sel = active ? fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
  assign rf_byp_rs = active && !id_nop && wb_regwrite && wb_rd != '0 && wb_rd == id_rs && id_use_rs;
  assign rf_byp_rt = active && !id_nop && wb_regwrite && wb_rd != '0 && wb_rd == id_rt && id_use_rt;
  assign stall_cnt = active ? cnt_q : '0;

  // LDSTALL, FLUSH and a MEMWAIT exit all re-evaluate like RUN; FLUSH only masks load-use.
  always_comb begin
    state_nxt   = RUN;
    pc_hold     = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    freeze_all  = 1'b0;
    if (active) begin
      if (mem_busy) begin
        freeze_all = 1'b1;
        pc_hold    = 1'b1;
        state_nxt  = MEMWAIT;
      end else if (ex_br_taken) begin
        flush_if_id = 1'b1;
        bubble_ex   = 1'b1;
        state_nxt   = FLUSH;
      end else if (load_use) begin
        pc_hold   = 1'b1;
        bubble_ex = 1'b1;
        state_nxt = LDSTALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      init  <= 1'b1;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      init  <= 1'b0;
      if (pc_hold && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else if (!freeze_all) begin
      if (bubble_ex || id_nop) begin
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end else begin
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed instruction sequences with literal expectations,
// then randomized traffic compared every cycle against a stage-record reference model.
module tb_hazard_fwd_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [RA_W-1:0]  id_rs, id_rt, id_rd;
  logic             id_use_rs, id_use_rt, id_regwrite, id_memread, ex_br_taken, mem_busy;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             rf_byp_rs, rf_byp_rt, pc_hold, bubble_ex, flush_if_id, freeze_all;
  logic [CNT_W-1:0] stall_cnt;

  hazard_fwd_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .rf_byp_rs(rf_byp_rs), .rf_byp_rt(rf_byp_rt),
    .pc_hold(pc_hold), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
    .freeze_all(freeze_all), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per pipeline stage holding the instruction that sits there.
  typedef struct { int rd; int rs; int rt; bit rw; bit mr; } instr_t;
  instr_t st_ex, st_mem, st_wb;
  instr_t nop_i = '{0, 0, 0, 1'b0, 1'b0};
  bit m_init, m_squash;
  int m_cnt;

  int e_fa, e_fb, e_cnt;
  bit e_bs, e_bt, e_ph, e_bub, e_fl, e_fz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int producer_sel(input int src);
    if (st_mem.rw && st_mem.rd != 0 && st_mem.rd == src) return 1;
    if (st_wb.rw && st_wb.rd != 0 && st_wb.rd == src)    return 2;
    return 0;
  endfunction

  function automatic bit wb_hits(input int src, input bit used);
    return used && st_wb.rw && st_wb.rd != 0 && st_wb.rd == src;
  endfunction

  task automatic model_eval();
    bit lu;
    {e_bs, e_bt, e_ph, e_bub, e_fl, e_fz} = '0;
    e_fa = 0; e_fb = 0; e_cnt = 0;
    if (!reset && !m_init) begin
      e_fa  = producer_sel(st_ex.rs);
      e_fb  = producer_sel(st_ex.rt);
      e_cnt = m_cnt;
      if (!m_squash) begin
        e_bs = wb_hits(int'(id_rs), id_use_rs);
        e_bt = wb_hits(int'(id_rt), id_use_rt);
      end
      lu = !m_squash && st_ex.mr && st_ex.rd != 0 &&
           ((st_ex.rd == int'(id_rs) && id_use_rs) || (st_ex.rd == int'(id_rt) && id_use_rt));
      if (mem_busy)         begin e_fz = 1; e_ph = 1; end
      else if (ex_br_taken) begin e_fl = 1; e_bub = 1; end
      else if (lu)          begin e_ph = 1; e_bub = 1; end
    end
  endtask

  task automatic model_update();
    bit was_squash;
    if (reset) begin
      st_ex = nop_i; st_mem = nop_i; st_wb = nop_i;
      m_init = 1; m_squash = 0; m_cnt = 0;
    end else begin
      was_squash = m_squash;
      m_init   = 0;
      m_squash = e_fl;
      if (e_ph && m_cnt < CMAX) m_cnt++;
      if (!e_fz) begin
        st_wb  = st_mem;
        st_mem = st_ex;
        if (e_bub || was_squash) st_ex = nop_i;
        else st_ex = '{int'(id_rd), int'(id_rs), int'(id_rt), id_regwrite, id_memread};
      end
    end
  endtask

  // One clock: advance the model at the edge, drive new ID inputs, then check every output.
  task automatic cyc(input bit rst, input int rs, input int rt, input bit urs, input bit urt,
                     input int rd, input bit rw, input bit mr, input bit br, input bit busy);
    logic [RA_W-1:0] v_rs, v_rt, v_rd;
    @(posedge clk);
    model_update();
    @(negedge clk);
    v_rs = rs[RA_W-1:0]; v_rt = rt[RA_W-1:0]; v_rd = rd[RA_W-1:0];
    reset = rst; id_rs = v_rs; id_rt = v_rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = v_rd; id_regwrite = rw; id_memread = mr; ex_br_taken = br; mem_busy = busy;
    #1;
    model_eval();
    chk("fwd_a_sel",   fwd_a_sel,   e_fa);
    chk("fwd_b_sel",   fwd_b_sel,   e_fb);
    chk("rf_byp_rs",   rf_byp_rs,   e_bs);
    chk("rf_byp_rt",   rf_byp_rt,   e_bt);
    chk("pc_hold",     pc_hold,     e_ph);
    chk("bubble_ex",   bubble_ex,   e_bub);
    chk("flush_if_id", flush_if_id, e_fl);
    chk("freeze_all",  freeze_all,  e_fz);
    chk("stall_cnt",   stall_cnt,   e_cnt);
  endtask

  task automatic nop(input bit busy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
  endtask

  initial begin
    reset = 1; id_rs = '0; id_rt = '0; id_rd = '0; id_use_rs = 0; id_use_rt = 0;
    id_regwrite = 0; id_memread = 0; ex_br_taken = 0; mem_busy = 0;
    st_ex = nop_i; st_mem = nop_i; st_wb = nop_i; m_init = 1; m_squash = 0; m_cnt = 0;

    // Reset cycle and first cycle after: hazard inputs present but all outputs quiet.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("rst_freeze", freeze_all, 0);
    chk("rst_flush", flush_if_id, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("init_freeze", freeze_all, 0);
    chk("init_cnt", stall_cnt, 0);
    nop(0);

    // lw r5 ; add r6,r5,r1
    cyc(0, 1, 2, 1, 1, 5, 1, 1, 0, 0);
    cyc(0, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_bubble", bubble_ex, 1);
    cyc(0, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("ldstall_hold", pc_hold, 0);
    chk("ldstall_cnt", stall_cnt, 1);
    nop(0);
    chk("lu_fwd_a", fwd_a_sel, 2);
    chk("lu_fwd_b", fwd_b_sel, 0);

    // add r3 ; sub r4,r3,r3 ; then a reader of r3 while add is in WB
    cyc(0, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    cyc(0, 3, 3, 1, 1, 4, 1, 0, 0, 0);
    nop(0);
    chk("exmem_fwd_a", fwd_a_sel, 1);
    chk("exmem_fwd_b", fwd_b_sel, 1);
    chk("exmem_nohold", pc_hold, 0);
    cyc(0, 3, 9, 1, 0, 0, 0, 0, 0, 0);
    chk("rf_byp_rs_lit", rf_byp_rs, 1);
    chk("rf_byp_rt_lit", rf_byp_rt, 0);

    // add r3 ; add r3 ; or r7,r3 -> youngest producer wins
    cyc(0, 1, 1, 1, 1, 3, 1, 0, 0, 0);
    cyc(0, 2, 2, 1, 1, 3, 1, 0, 0, 0);
    cyc(0, 3, 0, 1, 1, 7, 1, 0, 0, 0);
    nop(0);
    chk("youngest_fwd_a", fwd_a_sel, 1);

    // r0 is never forwarded and never stalls
    cyc(0, 1, 1, 1, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 8, 1, 0, 0, 0);
    nop(0);
    chk("r0_fwd_a", fwd_a_sel, 0);
    chk("r0_fwd_b", fwd_b_sel, 0);
    cyc(0, 1, 1, 1, 1, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 8, 1, 0, 0, 0);
    chk("lw_r0_hold", pc_hold, 0);

    // Branch wins over a pending load-use; flush shadow cycle is quiet
    cyc(0, 1, 2, 1, 1, 5, 1, 1, 0, 0);
    cyc(0, 5, 5, 1, 1, 6, 1, 0, 1, 0);
    chk("br_flush", flush_if_id, 1);
    chk("br_bubble", bubble_ex, 1);
    chk("br_nohold", pc_hold, 0);
    cyc(0, 5, 5, 1, 1, 6, 1, 1, 0, 0);
    chk("flush_q_hold", pc_hold, 0);
    chk("flush_q_bub", bubble_ex, 0);
    chk("flush_q_flush", flush_if_id, 0);

    // mem_busy for 3 cycles while sub is forwarding from add
    cyc(0, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    cyc(0, 3, 3, 1, 1, 4, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      nop(1);
      chk("busy_freeze", freeze_all, 1);
      chk("busy_fwd_a", fwd_a_sel, 1);
      chk("busy_fwd_b", fwd_b_sel, 1);
    end
    nop(0);
    chk("busy_cnt", stall_cnt, 4);
    chk("busy_exit_fwd_a", fwd_a_sel, 1);

    // Reset during the second busy cycle
    nop(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("midrst_freeze", freeze_all, 0);
    chk("midrst_cnt", stall_cnt, 0);
    nop(0);
    chk("postrst_hold", pc_hold, 0);
    chk("postrst_cnt", stall_cnt, 0);

    // Counter saturation
    for (int i = 0; i < CMAX + 5; i++) nop(1);
    nop(0);
    chk("cnt_sat", stall_cnt, CMAX);

    // Randomized traffic on a small register pool to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 59) == 0,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
